// File: rtl/ddr_align_pkg.sv
// Shared types and width helpers for the DDR input word aligner.
package ddr_align_pkg;

  typedef enum logic [1:0] {SEARCH, BLANK, VERIFY, LOCKED} lane_state_t;

  function automatic int offset_bits(input int word_bits);
    return (word_bits > 2) ? $clog2(word_bits) : 1;
  endfunction

  function automatic int count_bits(input int lock_count);
    return $clog2(lock_count + 1);
  endfunction

endpackage

// File: rtl/ddr_lane_aligner.sv
// One lane: DDR bit-pair history, bit-slip word mux, word register and
// the training FSM that walks the slip offset until the pattern locks.
module ddr_lane_aligner
  import ddr_align_pkg::*;
#(
  parameter int                   WORD_BITS     = 8,
  parameter logic [WORD_BITS-1:0] TRAIN_PATTERN = 8'h1E,
  parameter int                   LOCK_COUNT    = 16,
  parameter int                   OFFSET_BITS   = offset_bits(WORD_BITS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   din0,
  input  logic                   din1,
  input  logic                   phase_last,
  input  logic                   train_en,
  output logic [WORD_BITS-1:0]   dout,
  output logic                   locked,
  output logic [OFFSET_BITS-1:0] offset
);

  localparam int HIST_BITS  = 2 * WORD_BITS;
  localparam int COUNT_BITS = count_bits(LOCK_COUNT);
  localparam logic [COUNT_BITS-1:0]  CNT_LAST = COUNT_BITS'(LOCK_COUNT - 1);
  localparam logic [OFFSET_BITS-1:0] OFS_LAST = OFFSET_BITS'(WORD_BITS - 1);

  logic [HIST_BITS-1:0]  hist, hist_next;
  logic [WORD_BITS-1:0]  word;
  logic                  match;
  logic [COUNT_BITS-1:0] count;
  lane_state_t           state;

  // din1 is the newest bit, so offset 0 is the word ending on the latest din1
  assign hist_next = {hist[HIST_BITS-3:0], din0, din1};
  assign word      = hist_next[offset +: WORD_BITS];
  assign match     = (word == TRAIN_PATTERN);

  // The two oldest history bits are shifted out before any word can use them.
  logic unused_hist_msbs;
  assign unused_hist_msbs = ^hist[HIST_BITS-1 -: 2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist   <= '0;
      dout   <= '0;
      state  <= SEARCH;
      offset <= '0;
      count  <= '0;
      locked <= 1'b0;
    end else begin
      hist <= hist_next;
      if (phase_last) begin
        dout <= word;
        if (train_en) begin
          case (state)
            SEARCH:
              if (match) begin
                count <= COUNT_BITS'(1);
                if (LOCK_COUNT == 1) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end else begin
                  state <= VERIFY;
                end
              end else begin
                offset <= (offset == OFS_LAST) ? '0 : offset + 1'b1;
                state  <= BLANK;
              end
            // one word is discarded after every slip before looking again
            BLANK: state <= SEARCH;
            VERIFY:
              if (match) begin
                count <= count + 1'b1;
                if (count == CNT_LAST) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                count <= '0;
                state <= SEARCH;
              end
            LOCKED:
              if (!match) begin
                count  <= '0;
                locked <= 1'b0;
                state  <= SEARCH;
              end
            default: state <= SEARCH;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/ddr_input_word_aligner.sv
// Deserializes DDR bit pairs into per-lane words; shared word phase,
// valid strobe and lock reduction live here, per-lane work in ddr_lane_aligner.
module ddr_input_word_aligner
  import ddr_align_pkg::*;
#(
  parameter int                   LANES         = 16,
  parameter int                   WORD_BITS     = 8,
  parameter logic [WORD_BITS-1:0] TRAIN_PATTERN = 8'h1E,
  parameter int                   LOCK_COUNT    = 16,
  parameter int                   OFFSET_BITS   = offset_bits(WORD_BITS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LANES-1:0]             din0,
  input  logic [LANES-1:0]             din1,
  input  logic                         train_en,
  output logic [LANES*WORD_BITS-1:0]   dout,
  output logic                         dout_valid,
  output logic [LANES-1:0]             lane_locked,
  output logic                         all_locked,
  output logic [LANES*OFFSET_BITS-1:0] lane_offset
);

  localparam int PHASE_BITS = (WORD_BITS / 2 > 1) ? $clog2(WORD_BITS / 2) : 1;
  localparam logic [PHASE_BITS-1:0] PHASE_LAST = PHASE_BITS'(WORD_BITS / 2 - 1);

  logic [PHASE_BITS-1:0]                   phase;
  logic                                    phase_last;
  logic [LANES-1:0][WORD_BITS-1:0]         lane_word;
  logic [LANES-1:0][OFFSET_BITS-1:0]       lane_ofs;

  assign phase_last  = (phase == PHASE_LAST);
  assign dout        = lane_word;
  assign lane_offset = lane_ofs;

  // Phase free-runs from reset; train_en only gates the lane FSMs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= '0;
      dout_valid <= 1'b0;
      all_locked <= 1'b0;
    end else begin
      phase      <= phase_last ? '0 : phase + 1'b1;
      dout_valid <= phase_last;
      all_locked <= &lane_locked;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    ddr_lane_aligner #(
      .WORD_BITS    (WORD_BITS),
      .TRAIN_PATTERN(TRAIN_PATTERN),
      .LOCK_COUNT   (LOCK_COUNT),
      .OFFSET_BITS  (OFFSET_BITS)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .din0      (din0[i]),
      .din1      (din1[i]),
      .phase_last(phase_last),
      .train_en  (train_en),
      .dout      (lane_word[i]),
      .locked    (lane_locked[i]),
      .offset    (lane_ofs[i])
    );
  end

endmodule

// File: tb/tb_ddr_input_word_aligner.sv
// Bench for ddr_input_word_aligner: bit-stream reference model plus
// hand-derived vector table and corner-case sequences.
module tb_ddr_input_word_aligner;

  localparam int         LANES = 2;
  localparam int         WB    = 8;
  localparam int         LC    = 4;
  localparam logic [7:0] PAT   = 8'h1E;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  din0 = '0, din1 = '0;
  logic        train_en = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic [1:0]  lane_locked;
  logic        all_locked;
  logic [5:0]  lane_offset;

  ddr_input_word_aligner #(
    .LANES(LANES), .WORD_BITS(WB), .TRAIN_PATTERN(PAT), .LOCK_COUNT(LC)
  ) dut (
    .clk(clk), .rst(rst), .din0(din0), .din1(din1), .train_en(train_en),
    .dout(dout), .dout_valid(dout_valid), .lane_locked(lane_locked),
    .all_locked(all_locked), .lane_offset(lane_offset)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: full received bit stream per lane, oldest first.
  bit          hq [LANES][$];
  int          m_run  [LANES];
  bit          m_skip [LANES];
  bit          m_lock [LANES];
  int          m_off  [LANES];
  logic [15:0] e_dout;
  bit          e_vld, e_all;
  int          edge_n;
  bit          dly[$];
  int          skew1 = 0;

  typedef struct {
    logic [7:0]  w0, w1;
    logic [1:0]  lock;
    logic [5:0]  ofs;
    logic [15:0] dout;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < LANES; l++) begin
      hq[l].delete();
      m_run[l] = 0; m_skip[l] = 0; m_lock[l] = 0; m_off[l] = 0;
    end
    e_dout = '0; e_vld = 0; e_all = 0; edge_n = 0;
    dly.delete();
    for (int i = 0; i < skew1; i++) dly.push_back(1'b0);
  endtask

  // Word ending offset bits before the newest bit, earliest bit as MSB.
  function automatic logic [7:0] m_word(input int l);
    int n;
    logic [7:0] w;
    n = hq[l].size();
    for (int k = 0; k < 8; k++) begin
      int idx;
      idx = n - 1 - m_off[l] - 7 + k;
      w[7-k] = (idx >= 0) ? hq[l][idx] : 1'b0;
    end
    return w;
  endfunction

  task automatic model_fsm(input int l, input logic [7:0] w);
    if (m_skip[l]) m_skip[l] = 0;
    else if (w == PAT) begin
      m_run[l]++;
      if (m_run[l] >= LC) m_lock[l] = 1;
    end else begin
      if (m_run[l] == 0) begin
        m_off[l]  = (m_off[l] + 1) % WB;
        m_skip[l] = 1;
      end
      m_run[l]  = 0;
      m_lock[l] = 0;
    end
  endtask

  task automatic check_outs(input string tag);
    logic [1:0] el;
    logic [5:0] eo;
    el = {m_lock[1], m_lock[0]};
    eo = {3'(m_off[1]), 3'(m_off[0])};
    chk({tag, ".dout"},   64'(dout),        64'(e_dout));
    chk({tag, ".valid"},  64'(dout_valid),  64'(e_vld));
    chk({tag, ".locked"}, 64'(lane_locked), 64'(el));
    chk({tag, ".all"},    64'(all_locked),  64'(e_all));
    chk({tag, ".offset"}, 64'(lane_offset), 64'(eo));
  endtask

  task automatic step(input logic [1:0] d0, input logic [1:0] d1);
    bit pa;
    din0 = d0; din1 = d1;
    @(posedge clk);
    pa = m_lock[0] & m_lock[1];
    for (int l = 0; l < LANES; l++) begin
      hq[l].push_back(d0[l]);
      hq[l].push_back(d1[l]);
    end
    edge_n++;
    e_vld = (edge_n % (WB / 2) == 0);
    e_all = pa;
    if (e_vld)
      for (int l = 0; l < LANES; l++) begin
        logic [7:0] w;
        w = m_word(l);
        e_dout[l*8 +: 8] = w;
        if (train_en) model_fsm(l, w);
      end
    #1 check_outs("step");
  endtask

  // Bit pair k of a word on each lane; lane 1 passes through a skew delay line.
  task automatic send_pair(input logic [7:0] w0, input logic [7:0] w1, input int k);
    bit a, b;
    dly.push_back(w1[7-2*k]); a = dly.pop_front();
    dly.push_back(w1[6-2*k]); b = dly.pop_front();
    step({a, w0[7-2*k]}, {b, w0[6-2*k]});
  endtask

  task automatic send_word(input logic [7:0] w0, input logic [7:0] w1);
    for (int k = 0; k < 4; k++) send_pair(w0, w1, k);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      din0 = 2'($urandom); din1 = 2'($urandom);
      @(posedge clk);
      #1 check_outs("rst");
    end
    rst = 1'b0;
  endtask

  initial begin
    // verify break on lane 1, steady pattern on lane 0
    tbl[0] = '{8'h1E, 8'h1E, 2'b00, 6'd0, 16'h1E1E};
    tbl[1] = '{8'h1E, 8'h1E, 2'b00, 6'd0, 16'h1E1E};
    tbl[2] = '{8'h1E, 8'h00, 2'b00, 6'd0, 16'h001E};
    tbl[3] = '{8'h1E, 8'h1E, 2'b01, 6'd0, 16'h1E1E};
    tbl[4] = '{8'h1E, 8'h1E, 2'b01, 6'd0, 16'h1E1E};
    tbl[5] = '{8'h1E, 8'h1E, 2'b01, 6'd0, 16'h1E1E};
    tbl[6] = '{8'h1E, 8'h1E, 2'b11, 6'd0, 16'h1E1E};

    // reset, then free-running valid strobe every 4 cycles
    skew1 = 0; train_en = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(2'($urandom), 2'($urandom));
      chk("vld_cadence", 64'(dout_valid), 64'(i % 4 == 3));
    end

    // aligned pattern: lock on 4th capture, all_locked one cycle later
    do_reset();
    train_en = 1'b1;
    for (int j = 0; j < 3; j++) send_word(PAT, PAT);
    chk("aligned_prelock", 64'(lane_locked), 64'(2'b00));
    send_word(PAT, PAT);
    chk("aligned_lock", 64'(lane_locked), 64'(2'b11));
    chk("aligned_all_lag", 64'(all_locked), 64'(1'b0));
    chk("aligned_dout", 64'(dout), 64'(16'h1E1E));
    send_pair(PAT, PAT, 0);
    chk("aligned_all", 64'(all_locked), 64'(1'b1));
    for (int k = 1; k < 4; k++) send_pair(PAT, PAT, k);
    chk("aligned_ofs", 64'(lane_offset), 64'(6'd0));

    // table: verify break on lane 1
    do_reset();
    train_en = 1'b1;
    foreach (tbl[j]) begin
      send_word(tbl[j].w0, tbl[j].w1);
      chk($sformatf("tbl%0d.lock", j), 64'(lane_locked), 64'(tbl[j].lock));
      chk($sformatf("tbl%0d.ofs", j),  64'(lane_offset), 64'(tbl[j].ofs));
      chk($sformatf("tbl%0d.dout", j), 64'(dout),        64'(tbl[j].dout));
    end

    // lane 1 delayed 3 bits: only offset 5 yields the pattern
    skew1 = 3;
    do_reset();
    train_en = 1'b1;
    for (int j = 0; j < 20; j++) send_word(PAT, PAT);
    chk("skew_lock", 64'(lane_locked), 64'(2'b11));
    chk("skew_ofs",  64'(lane_offset), 64'({3'd5, 3'd0}));

    // freeze: lock, drop train_en, random words
    skew1 = 0;
    do_reset();
    train_en = 1'b1;
    for (int j = 0; j < 5; j++) send_word(PAT, PAT);
    train_en = 1'b0;
    for (int j = 0; j < 50; j++) send_word(8'($urandom), 8'($urandom));
    chk("freeze_lock", 64'(lane_locked), 64'(2'b11));
    chk("freeze_ofs",  64'(lane_offset), 64'(6'd0));

    // random noise then pattern at random lane 1 skew
    for (int r = 0; r < 3; r++) begin
      skew1 = $urandom_range(0, 7);
      do_reset();
      train_en = 1'b1;
      for (int j = 0; j < 6; j++) send_word(8'($urandom), 8'($urandom));
      for (int j = 0; j < 30; j++) send_word(PAT, PAT);
      chk($sformatf("rand%0d_lock", r), 64'(lane_locked), 64'(2'b11));
      chk($sformatf("rand%0d_ofs", r), 64'(lane_offset),
          64'({3'((WB - skew1) % WB), 3'd0}));
    end

    // asynchronous reset while lanes are in VERIFY
    skew1 = 0;
    do_reset();
    train_en = 1'b1;
    send_word(PAT, PAT);
    send_word(PAT, PAT);
    #2 rst = 1'b1;
    #1;
    chk("midrst_dout",   64'(dout),        64'(0));
    chk("midrst_valid",  64'(dout_valid),  64'(0));
    chk("midrst_locked", 64'(lane_locked), 64'(0));
    chk("midrst_all",    64'(all_locked),  64'(0));
    chk("midrst_ofs",    64'(lane_offset), 64'(0));
    do_reset();
    for (int j = 0; j < 4; j++) send_word(PAT, PAT);
    chk("midrst_relock", 64'(lane_locked), 64'(2'b11));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_input_word_aligner.md
Name: ddr_input_word_aligner

Overview:
Consumes the per-lane rising/falling bit pairs produced by the ganged DDR input buffer and deserializes them into WORD_BITS-wide words per lane. A per-lane training FSM bit-slips each lane until a known training pattern is found and confirmed, then holds that alignment. It sits directly downstream of the DDR input buffer, in the same clock domain as the buffer's pipelined outputs.

Parameters:
LANES, 16, number of parallel DDR input lanes
WORD_BITS, 8, output word width per lane; must be even and >= 4
TRAIN_PATTERN, 8'h1E, WORD_BITS-wide training word; all rotations must be distinct
LOCK_COUNT, 16, consecutive matching words required to declare lock (1..255)

Ports:
clk  in  1  capture clock, same as the DDR buffer's clk_p
rst  in  1  asynchronous, active-high reset
din0  in  LANES  first-in-time bit of each lane's DDR pair
din1  in  LANES  second-in-time bit of each lane's DDR pair
train_en  in  1  1 = FSMs active (training pattern on the bus); 0 = freeze all alignment state
dout  out  LANES*WORD_BITS  lane i word at [i*WORD_BITS +: WORD_BITS]; MSB is the earliest bit in time
dout_valid  out  1  one-cycle strobe that a new word is present on all lanes
lane_locked  out  LANES  per-lane lock flag
all_locked  out  1  registered AND of lane_locked
lane_offset  out  LANES*$clog2(WORD_BITS)  current bit-slip offset per lane, for debug

Behaviour:
- Reset (async assert, sync release): dout=0, dout_valid=0, lane_locked=0, all_locked=0, lane_offset=0, phase=0, all FSMs in SEARCH, match counters=0, history=0.
- History: per-lane 2*WORD_BITS shift register. Each cycle it shifts left by 2, din0 entering above din1, so din1 is the newest bit (LSB).
- Phase: a shared counter that runs 0..WORD_BITS/2-1 and wraps. It free-runs after reset, independent of train_en.
- Word capture: on the cycle where phase==WORD_BITS/2-1, each lane loads dout <= hist_next[offset +: WORD_BITS], where hist_next is the post-shift history. dout_valid is high for exactly the following cycle.
- Latency: the last bit of a word arrives on din1 at cycle t, and the word is visible on dout with dout_valid=1 at cycle t+1. dout holds its value between strobes.
- The per-lane FSM evaluates only on word captures while train_en=1.
  - SEARCH: if word==TRAIN_PATTERN, go to VERIFY with count=1. Otherwise offset=(offset+1) mod WORD_BITS and go to BLANK.
  - BLANK: ignore one captured word, then return to SEARCH.
  - VERIFY: on a match, count++; when count reaches LOCK_COUNT, go to LOCKED and set lane_locked. On a mismatch, go to SEARCH with count=0 and the offset unchanged.
  - LOCKED: a match holds the state. A mismatch clears lane_locked and goes to SEARCH with count=0.
  - If LOCK_COUNT==1, the first match goes straight to LOCKED.
- train_en=0: state, offset, count and lane_locked are all frozen; words still flow to dout. A train_en transition takes effect from the next capture.
- Offset wraps from WORD_BITS-1 to 0 and searching continues indefinitely; there is no timeout.
- all_locked is updated one cycle after lane_locked.
- Reset asserted mid-training immediately restores every reset value.

Decomposition:
- Package ddr_align_pkg holds:
  - enum lane_state_t {SEARCH, BLANK, VERIFY, LOCKED}
  - the OFFSET_BITS and COUNT_BITS width helpers
- Sub-module ddr_lane_aligner holds the per-lane history, offset mux, dout register, FSM and counter. It takes phase_last as an input.
- The top level owns the phase counter, dout_valid, and the all_locked reduction, and generates LANES instances of ddr_lane_aligner.

Test Plan:
Settings for every scenario: LANES=2, WORD_BITS=8, LOCK_COUNT=4, TRAIN_PATTERN=8'h1E.
- Reset: hold rst with random din -> all outputs 0. After release, dout_valid pulses every 4 cycles, first at cycle 4.
- Aligned pattern: drive repeating 0x1E on both lanes at skew 0 with train_en=1 -> offsets stay 0, lane_locked=2'b11 on the 4th matching capture, all_locked follows 1 cycle later, dout=16'h1E1E.
- Skewed lane: lane 1 delayed 3 bits -> lane 1 reaches the offset that yields 0x1E (exactly one), locks within 2*8+4 captures; lane 0 is unaffected.
- Verify break: 0x1E x2, then 0x00, then 0x1E continuous -> lane returns to SEARCH with the offset unchanged, then locks 4 captures after resuming.
- Freeze: lock both lanes, drop train_en, drive random data for 50 words -> lane_locked stays 11, lane_offset unchanged, dout tracks the data.
- Mid-operation reset: assert rst while lane 0 is in VERIFY -> all outputs 0 immediately; re-training from SEARCH locks normally.
